seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_prescaler.sv | 31 +++
 rtl/seg7_scan.sv | 137 +++++++++++++
 tb/tb_seg7_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 6-digit seg7 scanner
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 3;
  localparam int PTR_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Digit positions are 1-based; 0 and 7 do not address a register.
  function automatic logic addr_valid(input logic [PTR_W-1:0] a);
    return (a >= PTR_W'(1)) && (a <= PTR_W'(NUM_DIGITS));
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// rtl/seg7_prescaler.sv - dwell counter with reload and terminal-count pulse
module seg7_prescaler #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  // Terminal count is the last cycle of the current dwell; the counter
  // reloads there so it never runs past the terminal value.
  assign w_tc = (r_cnt == i_term);
  assign o_tc = w_tc;

  // Count up from zero; reload on request or on terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - six-digit multiplexed display scanner with digit register file
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic               scan_en,
  output logic [DIGIT_W-1:0] data1,
  output logic [PTR_W-1:0]   data2,
  output logic               frame_done
);

  localparam int DWELL_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W     = (DWELL_MAX > 2) ? $clog2(DWELL_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [DIGIT_W-1:0] r_data1;
  logic [DIGIT_W-1:0] w_data1_nxt;
  logic [PTR_W-1:0]   r_data2;
  logic [PTR_W-1:0]   w_data2_nxt;
  logic               r_frame_done;
  logic               w_frame_done_nxt;
  logic [DIGIT_W-1:0] r_digit [NUM_DIGITS];
  logic               w_load;
  logic               w_tc;
  logic [CNT_W-1:0]   w_term;

  // Counter restarts whenever we are not actively scanning, so each
  // dwell begins at zero on the entry edge of SHOW or BLANK.
  assign w_load = (r_state == ST_IDLE) || !scan_en;
  assign w_term = (r_state == ST_SHOW) ? SHOW_TC : BLANK_TC;

  seg7_prescaler #(
    .W(CNT_W)
  ) u_prescaler (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  // Register file write; reset clears all digits and drops a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= '0;
      end
    end else if (wr_en && addr_valid(wr_addr)) begin
      r_digit[wr_addr - PTR_W'(1)] <= wr_data;
    end
  end

  // Next-state and next-output logic; digit data is read from the register
  // file before any same-edge write lands, so entry shows the old value.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_data1_nxt      = '0;
    w_data2_nxt      = '0;
    w_frame_done_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ptr_nxt = PTR_W'(1);
        if (scan_en) begin
          w_state_nxt = ST_SHOW;
          w_data2_nxt = PTR_W'(1);
          w_data1_nxt = r_digit[0];
        end
      end
      ST_SHOW: begin
        if (!scan_en) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = PTR_W'(1);
        end else if (w_tc) begin
          w_state_nxt = ST_BLANK;
        end else begin
          w_data1_nxt = r_data1;
          w_data2_nxt = r_data2;
        end
      end
      ST_BLANK: begin
        if (!scan_en) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = PTR_W'(1);
        end else if (w_tc) begin
          w_state_nxt = ST_SHOW;
          if (r_ptr == PTR_W'(NUM_DIGITS)) begin
            w_ptr_nxt        = PTR_W'(1);
            w_frame_done_nxt = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
          w_data2_nxt = w_ptr_nxt;
          w_data1_nxt = r_digit[w_ptr_nxt - PTR_W'(1)];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = PTR_W'(1);
      end
    endcase
  end

  // State, pointer and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= PTR_W'(1);
      r_data1      <= '0;
      r_data2      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_data1      <= w_data1_nxt;
      r_data2      <= w_data2_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign data1      = r_data1;
  assign data2      = r_data2;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan with DIV=4, BLANK=1
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int SLOT  = DIV + BLANK;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       scan_en;
  logic [2:0] data1;
  logic [2:0] data2;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scan_en    (scan_en),
    .data1      (data1),
    .data2      (data2),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: time since scan start decides slot and phase.
  int m_digit [1:6];
  bit m_active;
  int m_k;
  int m_lat;
  int e_d1, e_d2, e_fd;

  initial begin : model
    int phase, slot;
    m_active = 0;
    m_k = 0;
    m_lat = 0;
    for (int i = 1; i <= 6; i++) m_digit[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      e_d1 = 0;
      e_d2 = 0;
      e_fd = 0;
      if (rst) begin
        m_active = 0;
        for (int i = 1; i <= 6; i++) m_digit[i] = 0;
      end else begin
        if (m_active && !scan_en) m_active = 0;
        else if (m_active) m_k++;
        else if (scan_en) begin
          m_active = 1;
          m_k = 0;
        end
        if (m_active) begin
          phase = m_k % SLOT;
          slot  = (m_k / SLOT) % 6;
          if (phase == 0) m_lat = m_digit[slot + 1];
          if (phase < DIV) begin
            e_d2 = slot + 1;
            e_d1 = m_lat;
          end
          e_fd = (m_k > 0 && (m_k % FRAME) == 0) ? 1 : 0;
        end
        if (wr_en && wr_addr >= 3'd1 && wr_addr <= 3'd6) m_digit[wr_addr] = int'(wr_data);
      end
      check("model_data1", 8'(data1), 8'(e_d1));
      check("model_data2", 8'(data2), 8'(e_d2));
      check("model_frame_done", 8'(frame_done), 8'(e_fd));
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 3'd0;
    scan_en = 1'b0;
    step(2);
    check("rst_data1", 8'(data1), 8'd0);
    check("rst_data2", 8'(data2), 8'd0);
    check("rst_fd", 8'(frame_done), 8'd0);
    rst = 1'b0;

    for (int i = 1; i <= 6; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 3'(6 - i);
      step(1);
    end
    wr_addr = 3'd0; wr_data = 3'd7; step(1);
    wr_addr = 3'd7; wr_data = 3'd7; step(1);
    wr_en = 1'b0;

    scan_en = 1'b1;
    step(1);
    check("k0_d2", 8'(data2), 8'd1);
    check("k0_d1", 8'(data1), 8'd5);
    check("k0_fd", 8'(frame_done), 8'd0);
    step(4);
    check("k4_blank_d2", 8'(data2), 8'd0);
    check("k4_blank_d1", 8'(data1), 8'd0);
    step(1);
    check("k5_d2", 8'(data2), 8'd2);
    check("k5_d1", 8'(data1), 8'd4);
    step(24);
    check("k29_d2", 8'(data2), 8'd0);
    step(1);
    check("k30_d2", 8'(data2), 8'd1);
    check("k30_fd", 8'(frame_done), 8'd1);
    check("k30_d1", 8'(data1), 8'd5);
    step(1);
    check("k31_fd", 8'(frame_done), 8'd0);

    step(9);
    check("k40_d2", 8'(data2), 8'd3);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 3'd7;
    step(1);
    wr_en = 1'b0;
    step(2);
    check("k43_d1_held", 8'(data1), 8'd3);
    check("k43_d2", 8'(data2), 8'd3);

    step(26);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 3'd1;
    step(1);
    wr_en = 1'b0;
    check("k70_d2", 8'(data2), 8'd3);
    check("k70_d1_old", 8'(data1), 8'd7);

    step(6);
    check("k76_d2", 8'(data2), 8'd4);
    scan_en = 1'b0;
    step(1);
    check("drop_d1", 8'(data1), 8'd0);
    check("drop_d2", 8'(data2), 8'd0);
    step(3);
    scan_en = 1'b1;
    step(1);
    check("restart_d2", 8'(data2), 8'd1);
    check("restart_d1", 8'(data1), 8'd5);

    step(9);
    check("blank2_d2", 8'(data2), 8'd0);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'd7;
    step(1);
    rst = 1'b0; wr_en = 1'b0;
    check("rstmid_d1", 8'(data1), 8'd0);
    check("rstmid_d2", 8'(data2), 8'd0);
    check("rstmid_fd", 8'(frame_done), 8'd0);
    step(1);
    check("post_rst_d2", 8'(data2), 8'd1);
    check("post_rst_d1", 8'(data1), 8'd0);
    check("post_rst_fd", 8'(frame_done), 8'd0);
    step(5);
    check("post_rst_k5_d2", 8'(data2), 8'd2);
    check("post_rst_k5_d1", 8'(data1), 8'd0);
    step(25);
    check("post_rst_k30_fd", 8'(frame_done), 8'd1);
    scan_en = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
